// File: rtl/adder_arb_pkg.sv
// Shared types and parameter defaults for the round-robin adder arbiter.
package adder_arb_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREQ_DEF  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_id, wrapping.
module rr_pick
  import adder_arb_pkg::*;
#(
  parameter int  NREQ = NREQ_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW:0]   cand;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    idx    = '0;
    // One spare bit so last_id + NREQ never overflows before the wrap.
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_id} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      idx = cand[IDW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one adder among NREQ requesters in round-robin order; result is
// registered and tagged with the requester index.
module adder_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// state | meaning
// EMPTY | result register holds nothing (rsp_valid=0)
// FULL  | result register holds an unconsumed result (rsp_valid=1)
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  NREQ  = NREQ_DEF,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  slot_state_t    state, state_nxt;
  logic [IDW-1:0] last_id;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           slot_free;
  logic           take;
  logic [WIDTH-1:0] a_sel, b_sel, sum_c;
  logic           cout_c;

  assign rsp_valid = (state == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // rst_n gates the picker so req_ready stays low while reset is held.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .last_id (last_id),
    .en      (slot_free && rst_n),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign req_ready = gnt;
  assign take      = |gnt;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder_core #(.WIDTH(WIDTH)) u_add (
    .a    (a_sel),
    .b    (b_sel),
    .sum  (sum_c),
    .cout (cout_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (take) state_nxt = FULL;
      FULL:    if (rsp_ready && !take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
      last_id  <= IDW'(NREQ-1);
    end else begin
      state <= state_nxt;
      if (take) begin
        rsp_sum  <= sum_c;
        rsp_cout <= cout_c;
        rsp_id   <= gnt_id;
        last_id  <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed and randomized checks for adder_rr_arbiter (WIDTH=64, NREQ=4).
module tb_adder_rr_arbiter;

  localparam int WIDTH = 64;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  adder_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    #3;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_checks++;
    if ({rsp_valid, rsp_cout, rsp_id, rsp_sum} !== '0) begin
      n_fail++; $display("FAIL reset_outputs valid=%b cout=%b id=%0d sum=%h exp all zero", rsp_valid, rsp_cout, rsp_id, rsp_sum);
    end
    step();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    req_a[0 +: WIDTH] = 64'd5;
    req_b[0 +: WIDTH] = 64'd7;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd12 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL post_reset_result valid=%b sum=%0d id=%0d exp 1/12/0", rsp_valid, rsp_sum, rsp_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL async_reset valid=%b sum=%h id=%0d exp 0/0/0", rsp_valid, rsp_sum, rsp_id);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_wrap();
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b[2*WIDTH +: WIDTH] = 64'd1;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL wrap_result valid=%b sum=%h cout=%b id=%0d exp 1/0/1/2", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd2 || rsp_cout !== 1'b1) begin
      n_fail++; $display("FAIL wrap_drain valid=%b id=%0d cout=%b exp 0/2/1 (stale hold)", rsp_valid, rsp_id, rsp_cout);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 64'(i * 100);
      req_b[i*WIDTH +: WIDTH] = 64'(i);
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== 64'((k % 4) * 101)) begin
        n_fail++; $display("FAIL rr_seq[%0d] valid=%b id=%0d sum=%0d exp 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_sum, k % 4, (k % 4) * 101);
      end
    end
  endtask

  // Follows round robin: register is FULL with id 1 (sum 101), last_id=1.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 64'd101) begin
        n_fail++; $display("FAIL bp_hold[%0d] valid=%b id=%0d sum=%0d exp 1/1/101", k, rsp_valid, rsp_id, rsp_sum);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'd202) begin
      n_fail++; $display("FAIL bp_release valid=%b id=%0d sum=%0d exp 1/2/202", rsp_valid, rsp_id, rsp_sum);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty valid=%b exp=0", rsp_valid); end
  endtask

  task automatic test_idle_priority();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL idle_first id=%0d exp=1", rsp_id); end
    repeat (3) step();
    req_valid = 4'b0101;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL idle_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0001;
    n_checks++;
    if (rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL idle_grant id=%0d valid=%b exp 2/1", rsp_id, rsp_valid); end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL idle_next id=%0d valid=%b exp 0/1", rsp_id, rsp_valid); end
    step();
  endtask

  task automatic test_random();
    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  exp_gnt;
    logic [1:0]       m_last;
    logic [1:0]       g, c;
    logic             m_full;
    logic             found;
    logic [WIDTH:0]   full_sum;
    logic [WIDTH+IDW:0] q[$];
    logic [WIDTH+IDW:0] front;
    int               pops = 0, pushes = 0;
    do_reset();
    pend = '0;
    m_last = 2'd3;
    m_full = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          req_a[i*WIDTH +: WIDTH] = {$urandom, $urandom};
          req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        end
      end
      req_valid = pend;
      #1;
      exp_gnt = '0;
      found = 1'b0;
      g = '0;
      if (!m_full || rsp_ready) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = m_last + 2'(k);
          if (!found && pend[c]) begin found = 1'b1; g = c; exp_gnt[c] = 1'b1; end
        end
      end
      n_checks++;
      if (req_ready !== exp_gnt || rsp_valid !== m_full) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d ready=%b exp=%b valid=%b exp=%b", cyc, req_ready, exp_gnt, rsp_valid, m_full);
      end
      if (m_full && rsp_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_pop cyc=%0d got a result exp none queued", cyc);
        end else begin
          front = q.pop_front();
          pops++;
          if ({rsp_id, rsp_cout, rsp_sum} !== front) begin
            n_fail++; $display("FAIL rnd_data cyc=%0d id=%0d cout=%b sum=%h exp id=%0d cout=%b sum=%h",
                               cyc, rsp_id, rsp_cout, rsp_sum, front[WIDTH+IDW:WIDTH+1], front[WIDTH], front[WIDTH-1:0]);
          end
        end
      end
      if (found) begin
        full_sum = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
        q.push_back({g, full_sum});
        pushes++;
        pend[g] = 1'b0;
        m_last = g;
        m_full = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      step();
    end
    n_checks++;
    if (pushes - pops !== q.size() || pushes < 500) begin
      n_fail++; $display("FAIL rnd_count pushes=%0d pops=%0d queued=%0d exp balanced and >=500 pushes", pushes, pops, q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single_wrap();
    test_round_robin();
    test_backpressure();
    test_idle_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
